// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text-mode path: screen geometry, text
// buffer sizing and the character/attribute cell layout used by both the
// text RAM and the display driver.
package vga_pkg;

    localparam int unsigned VGA_COLS   = 80;
    localparam int unsigned VGA_ROWS   = 60;
    localparam int unsigned TEXT_WORDS = (VGA_COLS * VGA_ROWS) / 2;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 32;

    // Field widths of one 8x8 character cell
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned CELL_W  = CHAR_W + 2 * COLOR_W;

    // Field positions inside a 32-bit text word
    localparam int unsigned CHAR0_LSB = 0;
    localparam int unsigned FG0_LSB   = 8;
    localparam int unsigned BG0_LSB   = 12;
    localparam int unsigned CHAR1_LSB = 16;
    localparam int unsigned FG1_LSB   = 24;
    localparam int unsigned BG1_LSB   = 28;

    // One cell: background in the top nibble, character code in the low byte
    typedef struct packed {
        logic [COLOR_W-1:0] bg;
        logic [COLOR_W-1:0] fg;
        logic [CHAR_W-1:0]  ch;
    } text_cell_t;

    // One stored word: cell 1 in the upper half, cell 0 in the lower half
    typedef struct packed {
        text_cell_t cell1;
        text_cell_t cell0;
    } text_word_t;

    // Clear sequencer states of the text RAM
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } text_ram_state_e;

    // Assemble a text word from its six fields
    function automatic text_word_t pack_cells(
        input logic [CHAR_W-1:0]  ch0,
        input logic [COLOR_W-1:0] fg0,
        input logic [COLOR_W-1:0] bg0,
        input logic [CHAR_W-1:0]  ch1,
        input logic [COLOR_W-1:0] fg1,
        input logic [COLOR_W-1:0] bg1
    );
        text_word_t w;
        w.cell0.ch = ch0;
        w.cell0.fg = fg0;
        w.cell0.bg = bg0;
        w.cell1.ch = ch1;
        w.cell1.fg = fg1;
        w.cell1.bg = bg1;
        return w;
    endfunction

endpackage

// File: rtl/vga_text_ram.sv
// Character/attribute buffer for the VGA text-mode driver.
// Single clock, dual port: byte-enabled CPU write port (A) and a registered
// pixel-pipeline read port (B). Optionally zero-fills itself after reset.
//
// Ports:
//   i_clk    clock for both ports, rising edge
//   i_rst    synchronous active-high reset
//   i_we     per-byte write enables
//   i_waddr  write word address
//   i_wdata  write data
//   i_raddr  read word address
//   o_rdata  registered read data (1-cycle latency, read-first)
//   o_busy   high during reset and while the clear sequence runs
module vga_text_ram #(
    parameter int unsigned ADDR_W         = vga_pkg::ADDR_W,
    parameter int unsigned DATA_W         = vga_pkg::DATA_W,
    parameter int unsigned DEPTH          = vga_pkg::TEXT_WORDS,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_busy
);
    import vga_pkg::*;

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Elaboration-time parameter sanity
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("vga_text_ram: DATA_W must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("vga_text_ram: DEPTH exceeds address space");
    end

    // Storage, zero at time zero so reads never return X
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    text_ram_state_e   state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NB-1:0]     mem_be_c;
    logic [IDX_W-1:0]  mem_idx_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic waddr_ok_c;
    logic raddr_ok_c;

    assign waddr_ok_c = ({1'b0, i_waddr} < DEPTH_A);
    assign raddr_ok_c = ({1'b0, i_raddr} < DEPTH_A);

    // Write-port mux: clear sequencer owns the port while clearing
    always_comb begin
        mem_be_c    = '0;
        mem_idx_c   = '0;
        mem_wdata_c = '0;
        if (state_q == ST_CLEAR) begin
            mem_be_c  = '1;
            mem_idx_c = cnt_q;
        end else if (waddr_ok_c) begin
            mem_be_c    = i_we;
            mem_idx_c   = IDX_W'(i_waddr);
            mem_wdata_c = i_wdata;
        end
    end

    // Byte-enabled write port; contents are left alone while in reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_c[b]) begin
                    mem[mem_idx_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
                end
            end
        end
    end

    // Next-state, clear counter, busy flag and read data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rdata_d = '0;
        unique case (state_q)
            ST_CLEAR: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                busy_d = 1'b0;
                // Array is read before this edge's write lands: read-first
                if (raddr_ok_c) begin
                    rdata_d = mem[IDX_W'(i_raddr)];
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_vga_text_ram.sv
// Directed self-checking bench for vga_text_ram (default parameters).
module tb_vga_text_ram;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2400;
    localparam int unsigned NB     = DATA_W / 8;
    localparam int          LIMIT  = 3000;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [NB-1:0]     i_we = '0;
    logic [ADDR_W-1:0] i_waddr = '0;
    logic [DATA_W-1:0] i_wdata = '0;
    logic [ADDR_W-1:0] i_raddr = '0;
    logic [DATA_W-1:0] o_rdata;
    logic              o_busy;

    int pass_cnt = 0;
    int total    = 0;
    int n;

    vga_text_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .CLEAR_ON_RESET(1)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_we(i_we),
        .i_waddr(i_waddr),
        .i_wdata(i_wdata),
        .i_raddr(i_raddr),
        .o_rdata(o_rdata),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Apply inputs, take one rising edge, settle just after it
    task automatic step(input logic [NB-1:0] we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra);
        i_we    = we;
        i_waddr = wa;
        i_wdata = wd;
        i_raddr = ra;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // Reset held for a few edges
        i_rst = 1'b1;
        repeat (3) step('0, '0, '0, 12'd0);
        check("reset_busy", 32'(o_busy), 32'd1);
        check("reset_rdata", o_rdata, 32'h0);

        // First clear; a user write to word 3 at clear index 100 must be lost
        i_rst = 1'b0;
        n = 0;
        do begin
            if (n == 100) step(4'hF, 12'd3, 32'h1234_5678, 12'd3);
            else          step('0, '0, '0, 12'd3);
            n++;
        end while (o_busy && n < LIMIT);
        check("clear_cycles", 32'(n), 32'd2400);

        step('0, '0, '0, 12'd0);
        check("post_clear_rd0", o_rdata, 32'h0);
        step('0, '0, '0, 12'd1234);
        check("post_clear_rd1234", o_rdata, 32'h0);
        step('0, '0, '0, 12'd2399);
        check("post_clear_rd2399", o_rdata, 32'h0);
        step('0, '0, '0, 12'd3);
        check("clear_drops_write", o_rdata, 32'h0);

        // Full-word write and read-back
        step(4'hF, 12'd5, 32'hF141_2F48, 12'd0);
        step('0, '0, '0, 12'd5);
        check("full_write", o_rdata, 32'hF141_2F48);

        // Byte-enable merge
        step(4'hF, 12'd7, 32'h1122_3344, 12'd0);
        step(4'h5, 12'd7, 32'hAABB_CCDD, 12'd0);
        step('0, '0, '0, 12'd7);
        check("byte_merge", o_rdata, 32'h11BB_33DD);

        // Same-address read and write: read-first
        step(4'hF, 12'd9, 32'hDEAD_BEEF, 12'd9);
        check("rw_same_old", o_rdata, 32'h0);
        step('0, '0, '0, 12'd9);
        check("rw_same_new", o_rdata, 32'hDEAD_BEEF);

        // Out-of-range write and read
        step(4'hF, 12'd2400, 32'h5555_AAAA, 12'd4095);
        check("oor_read", o_rdata, 32'h0);
        step('0, '0, '0, 12'd0);
        check("oor_no_alias0", o_rdata, 32'h0);
        step('0, '0, '0, 12'd2399);
        check("oor_no_alias2399", o_rdata, 32'h0);

        // Top in-range word
        step(4'hF, 12'd2399, 32'h0BAD_F00D, 12'd0);
        step('0, '0, '0, 12'd2399);
        check("last_word", o_rdata, 32'h0BAD_F00D);

        // i_we = 0 is a no-op
        step('0, 12'd5, 32'hFFFF_FFFF, 12'd0);
        step('0, '0, '0, 12'd5);
        check("we_zero", o_rdata, 32'hF141_2F48);

        // Reset forces o_rdata to 0 even though word 7 is nonzero
        i_rst = 1'b1;
        step('0, '0, '0, 12'd7);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_busy", 32'(o_busy), 32'd1);

        // First clear cycle: o_rdata forced to 0 while word 7 still holds data
        i_rst = 1'b0;
        step('0, '0, '0, 12'd7);
        check("clear_rdata_forced", o_rdata, 32'h0);
        repeat (999) step('0, '0, '0, 12'd7);

        // Reset at clear index 1000
        i_rst = 1'b1;
        step('0, '0, '0, 12'd7);
        check("midclear_rdata", o_rdata, 32'h0);
        check("midclear_busy", 32'(o_busy), 32'd1);

        // Restarted clear takes the full length; write to word 10 lost
        i_rst = 1'b0;
        n = 0;
        do begin
            if (n == 500) step(4'hF, 12'd10, 32'hCAFE_0010, 12'd0);
            else          step('0, '0, '0, 12'd0);
            n++;
        end while (o_busy && n < LIMIT);
        check("restart_cycles", 32'(n), 32'd2400);

        step('0, '0, '0, 12'd10);
        check("restart_drops_write", o_rdata, 32'h0);
        step('0, '0, '0, 12'd5);
        check("restart_cleared5", o_rdata, 32'h0);

        // First write right after busy falls is accepted
        step(4'hF, 12'd11, 32'h0123_4567, 12'd0);
        step('0, '0, '0, 12'd11);
        check("first_write_after", o_rdata, 32'h0123_4567);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
